// File: rtl/aes_engine_ctrl.sv
// rtl/aes_engine_ctrl.sv - AES engine block sequencer: load, run, drain per block.
// Optional RUN watchdog enabled by defining AES_CTRL_TIMEOUT_EN.
module aes_engine_ctrl #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int CNT_W           = 16,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic                               clear_i,
  input  logic [CNT_W-1:0]                   n_blocks_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  output logic                               engine_load_o,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] engine_word_idx_o,
  output logic                               engine_start_o,
  input  logic                               engine_done_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o,
  output logic [CNT_W-1:0]                   blk_cnt_o
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  if (WORDS_PER_BLOCK < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("aes_engine_ctrl: WORDS_PER_BLOCK must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] blk_q, blk_d, nblk_q, nblk_d, blk_inc;
  logic             first_q, first_d;
  logic             in_hs, out_hs;

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
`endif

  assign in_hs   = (state_q == S_LOAD) & in_valid_i;
  assign out_hs  = (state_q == S_DRAIN) & out_ready_i;
  assign blk_inc = blk_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    blk_d   = blk_q;
    nblk_d  = nblk_q;
    first_d = 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = err_q;
`endif
    if (clear_i) begin
      state_d = S_IDLE;
      word_d  = '0;
      blk_d   = '0;
`ifdef AES_CTRL_TIMEOUT_EN
      tcnt_d  = '0;
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          word_d  = '0;
          blk_d   = '0;
          nblk_d  = n_blocks_i;
          state_d = (n_blocks_i == '0) ? S_DONE : S_LOAD;
`ifdef AES_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
        S_LOAD: if (in_hs) begin
          word_d = word_q + 1'b1;
          if (word_q == LAST_IDX) begin
            state_d = S_RUN;
            first_d = 1'b1;
`ifdef AES_CTRL_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
        // engine_done_i wins over a watchdog expiry in the same cycle
        S_RUN: begin
          if (engine_done_i) begin
            state_d = S_DRAIN;
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
`endif
        end
        S_DRAIN: if (out_hs) begin
          word_d = word_q + 1'b1;
          if (word_q == LAST_IDX) begin
            blk_d   = blk_inc;
            state_d = (blk_inc == nblk_q) ? S_DONE : S_LOAD;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      blk_q   <= '0;
      nblk_q  <= '0;
      first_q <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      blk_q   <= blk_d;
      nblk_q  <= nblk_d;
      first_q <= first_d;
`ifdef AES_CTRL_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready_o        = (state_q == S_LOAD);
  assign engine_load_o     = in_valid_i & in_ready_o;
  assign engine_word_idx_o = word_q;
  assign engine_start_o    = (state_q == S_RUN) & first_q;
  assign out_valid_o       = (state_q == S_DRAIN);
  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = (state_q == S_DONE) & ~clear_i;
  assign blk_cnt_o         = blk_q;
`ifdef AES_CTRL_TIMEOUT_EN
  assign err_o             = err_q;
`else
  assign err_o             = 1'b0;
`endif

endmodule

// File: tb/tb_aes_engine_ctrl.sv
// tb/tb_aes_engine_ctrl.sv - scoreboard bench for aes_engine_ctrl.
module tb_aes_engine_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, clear_i;
  logic [15:0] n_blocks_i;
  logic        in_valid_i, out_ready_i, engine_done_i;
  logic        in_ready_o, engine_load_o, engine_start_o, out_valid_o;
  logic        busy_o, done_o, err_o;
  logic [1:0]  engine_word_idx_o;
  logic [15:0] blk_cnt_o;

  int tests = 0, fails = 0;
  int load_cnt, start_cnt, out_cnt, done_cnt;
  int eng_lat = 0, eng_cnt = 0;
  bit eng_hold = 0, pend = 0, rnd_in = 0, rnd_out = 0;
  int load_q[$];
  int out_q[$];

  always #5 clk = ~clk;

  aes_engine_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .clear_i(clear_i),
    .n_blocks_i(n_blocks_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .engine_load_o(engine_load_o), .engine_word_idx_o(engine_word_idx_o),
    .engine_start_o(engine_start_o), .engine_done_i(engine_done_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      in_valid_i  = rnd_in  ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready_i = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Engine model: raises engine_done_i eng_lat cycles after engine_start_o, for one cycle.
  always @(negedge clk) begin
    if (rst) pend = 0;
    else if (engine_start_o) begin pend = 1; eng_cnt = eng_lat; end
    else if (pend && eng_cnt == 0) pend = 0;
    else if (pend) eng_cnt--;
    engine_done_i = pend && eng_cnt == 0 && !eng_hold;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (engine_load_o) begin
        load_cnt++;
        if (load_q.size() == 0) check("load_unexpected", 32'(engine_word_idx_o), 32'hFFFF);
        else check("load_idx", 32'(engine_word_idx_o), 32'(load_q.pop_front()));
      end
      if (out_valid_o && out_ready_i) begin
        out_cnt++;
        if (out_q.size() == 0) check("out_unexpected", 32'(engine_word_idx_o), 32'hFFFF);
        else check("out_idx", 32'(engine_word_idx_o), 32'(out_q.pop_front()));
      end
      if (engine_start_o) start_cnt++;
      if (done_o) done_cnt++;
    end
  end

  task automatic prep(input int n, input bit with_out);
    load_q.delete(); out_q.delete();
    load_cnt = 0; start_cnt = 0; out_cnt = 0; done_cnt = 0;
    for (int b = 0; b < n; b++)
      for (int w = 0; w < 4; w++) begin
        load_q.push_back(w);
        if (with_out) out_q.push_back(w);
      end
  endtask

  task automatic start_job(input int n);
    @(posedge clk); #1;
    start_i = 1'b1; n_blocks_i = 16'(n);
    @(posedge clk); #1;
    start_i = 1'b0; n_blocks_i = 16'hBEEF;
  endtask

  task automatic wait_done(input int limit, output int cyc, output bit got);
    cyc = 0; got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (done_o) got = 1;
    end
    check("done_seen", 32'(got), 1);
  endtask

  task automatic run_job(input int n, input int lat, input bit rin, input bit rout, input int exp_cyc);
    int cyc; bit got;
    rnd_in = rin; rnd_out = rout; eng_lat = lat;
    prep(n, 1);
    start_job(n);
    if (n != 0) check("load_entry", 32'(in_ready_o), 1);
    wait_done(3000, cyc, got);
    if (exp_cyc > 0) check("job_latency", 32'(cyc), 32'(exp_cyc));
    check("blk_cnt_done", 32'(blk_cnt_o), 32'(n));
    @(negedge clk);
    check("busy_after", 32'(busy_o), 0);
    check("load_count", 32'(load_cnt), 32'(4 * n));
    check("start_count", 32'(start_cnt), 32'(n));
    check("out_count", 32'(out_cnt), 32'(4 * n));
    check("done_count", 32'(done_cnt), 1);
    check("queues_empty", 32'(load_q.size() + out_q.size()), 0);
    rnd_in = 0; rnd_out = 0;
  endtask

  initial begin
    int cyc, k; bit got;
    rst = 1'b1; start_i = 1'b0; clear_i = 1'b0; n_blocks_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'({in_ready_o, out_valid_o, engine_load_o, engine_start_o,
                             busy_o, done_o, err_o, engine_word_idx_o, blk_cnt_o}), 0);
    @(posedge clk); #1 rst = 1'b0;

    run_job(1, 3, 0, 0, 13);
    run_job(3, $urandom_range(0, 4), 1, 1, 0);
    run_job(3, 0, 1, 1, 0);
    run_job(0, 0, 0, 0, 1);
    run_job(2, 0, 0, 0, 19);

    // clear during RUN of the second block
    eng_lat = 10;
    prep(4, 1);
    start_job(4);
    k = 0;
    for (int i = 0; i < 500 && k < 2; i++) begin
      @(negedge clk);
      if (engine_start_o) k++;
    end
    check("clr_reach_run2", 32'(k), 2);
    check("clr_blk_before", 32'(blk_cnt_o), 1);
    @(posedge clk); #1 clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
    @(negedge clk);
    check("clr_busy", 32'(busy_o), 0);
    check("clr_blk", 32'(blk_cnt_o), 0);
    repeat (20) @(negedge clk);
    check("clr_no_done", 32'(done_cnt), 0);
    run_job(1, 0, 0, 0, 10);

`ifdef AES_CTRL_TIMEOUT_EN
    eng_hold = 1;
    prep(1, 0);
    start_job(1);
    wait_done(300, cyc, got);
    check("wd_latency", 32'(cyc), 69);
    check("wd_err", 32'(err_o), 1);
    check("wd_no_out", 32'(out_cnt), 0);
    @(negedge clk);
    check("wd_err_sticky", 32'(err_o), 1);
    eng_hold = 0;
    prep(1, 1);
    start_job(1);
    check("wd_err_cleared", 32'(err_o), 0);
    wait_done(300, cyc, got);
`else
    eng_hold = 1;
    prep(1, 0);
    start_job(1);
    repeat (100) @(negedge clk);
    check("nowd_busy", 32'(busy_o), 1);
    check("nowd_no_out", 32'(out_valid_o), 0);
    check("nowd_err", 32'(err_o), 0);
    check("nowd_no_done", 32'(done_cnt), 0);
    @(posedge clk); #1 clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
    eng_hold = 0;
    repeat (3) @(negedge clk);
`endif

    // asynchronous reset in the middle of DRAIN
    eng_lat = 0;
    prep(1, 1);
    start_job(1);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (out_valid_o && engine_word_idx_o == 2'd2) got = 1;
    end
    check("drain_word2", 32'(got), 1);
    #1 rst = 1'b1;
    #1 check("rst_async_outs", 32'({in_ready_o, out_valid_o, engine_load_o, engine_start_o,
                                   busy_o, done_o, err_o, engine_word_idx_o, blk_cnt_o}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_idle", 32'(busy_o), 0);
    run_job(1, 0, 0, 0, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_engine_ctrl.md
# aes_engine_ctrl

Sequencing controller for the AES HWPE engine datapath. Sits between the HWPE streamer and the engine. It accepts a job of N 128-bit blocks, gates the 32-bit input word stream into the engine four words per block, and triggers one engine run per block. It then drains four result words per block to the output stream and signals completion to the HWPE control slave.

## Interface
Parameters:
- WORDS_PER_BLOCK, 4, 32-bit words per AES block (power of two, ≥2)
- CNT_W, 16, width of block count
- TIMEOUT_CYCLES, 64, RUN-state watchdog limit (used only with macro)

Ports:
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  job start pulse; honoured only in IDLE
- clear_i  in  1  synchronous soft clear
- n_blocks_i  in  CNT_W  blocks in job; sampled on accepted start_i
- in_valid_i  in  1  input stream valid
- in_ready_o  out  1  input stream ready
- engine_load_o  out  1  engine captures input word this cycle
- engine_word_idx_o  out  log2(WORDS_PER_BLOCK)  word slot for load/drain
- engine_start_o  out  1  one-cycle pulse: run engine on loaded block
- engine_done_i  in  1  engine result valid
- out_valid_o  out  1  output stream valid
- out_ready_i  in  1  output stream ready
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle job-complete pulse
- err_o  out  1  sticky watchdog error
- blk_cnt_o  out  CNT_W  completed blocks in current job

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - start_i with n_blocks_i≠0 → LOAD. Latch n_blocks. Clear blk_cnt, word_cnt, err_o.
  - start_i with n_blocks_i=0 → DONE.
- LOAD:
  - in_ready_o=1.
  - engine_load_o = in_valid_i & in_ready_o (combinational).
  - engine_word_idx_o = word_cnt.
  - word_cnt increments per handshake.
  - Handshake at word_cnt=WORDS_PER_BLOCK-1 → RUN, word_cnt wraps to 0.
- RUN:
  - engine_start_o=1 in the first RUN cycle only.
  - engine_done_i is sampled in every RUN cycle, including the first; engine_done_i=1 → DRAIN.
- DRAIN:
  - out_valid_o=1; engine_word_idx_o = word_cnt.
  - Each out_valid_o & out_ready_i handshake increments word_cnt.
  - On the last word, blk_cnt increments. Then blk_cnt(new)=n_blocks → DONE, else → LOAD.
- DONE: done_o=1 for one cycle → IDLE.
- Priority, highest first: rst_i, then clear_i, then FSM.
  - clear_i → IDLE next edge; counters and err_o zeroed; no done_o.
- start_i outside IDLE is ignored. n_blocks_i is ignored after it is latched.
- engine_done_i outside RUN is ignored.
- in_ready_o and out_valid_o are Moore outputs (state decode) and never depend on the opposite valid/ready.
- Counters wrap never: blk_cnt ≤ n_blocks ≤ 2^CNT_W-1.

## Timing
- Reset values: in_ready_o, out_valid_o, engine_load_o, engine_start_o, busy_o, done_o, err_o = 0; blk_cnt_o, engine_word_idx_o = 0; state IDLE.
- start_i at edge t → LOAD visible in cycle t+1 (in_ready_o=1).
- Last input handshake at edge k → engine_start_o high in cycle k+1.
- Minimum block time: WORDS_PER_BLOCK + 1 + WORDS_PER_BLOCK cycles (9 for default), with zero stalls and engine_done_i in the first RUN cycle.
- Job done_o asserts one cycle after the final output handshake.
- Reset mid-operation: outputs return to reset values immediately (asynchronous), with no done_o.

## Configuration
- AES_CTRL_TIMEOUT_EN:
  - Defined:
    - A RUN cycle counter (clog2(TIMEOUT_CYCLES+1) bits) is zeroed on RUN entry.
    - When the counter reaches TIMEOUT_CYCLES without engine_done_i: set err_o, → DONE (done_o pulse), skip DRAIN.
    - engine_done_i in the same cycle as the limit wins: → DRAIN, no error.
  - Undefined: no counter; err_o tied 0; RUN waits indefinitely.

## Test plan
- Single block: reset, start n=1, four back-to-back input words, engine_done_i 3 cycles after engine_start_o, out_ready_i=1 → engine_load_o idx 0,1,2,3; one engine_start_o; out beats idx 0..3; done_o one cycle; blk_cnt_o=1; busy_o low next cycle.
- n=3 with random in_valid_i gaps and out_ready_i toggling 50% → exactly 12 loads, 3 start pulses, 12 output beats in order 0..3 per block, blk_cnt_o=3, one done_o.
- start with n_blocks_i=0 → busy_o for one cycle, done_o, no engine_load_o/engine_start_o/out_valid_o.
- clear_i during RUN of block 2 of n=4 → IDLE next cycle; blk_cnt_o=0; no done_o. A subsequent start with n=1 completes normally.
- Watchdog (macro defined, TIMEOUT_CYCLES=64):
  - engine_done_i held 0 → after 64 RUN cycles err_o=1, done_o pulse, no out_valid_o.
  - Next start clears err_o.
  - Macro undefined → remains in RUN.
- Assert rst_i mid-DRAIN (word 2) → all outputs 0 in the same cycle. After release, state is IDLE and start n=1 works.
